hex_calculator: RTL and testbench

- Four-digit hexadecimal keypad calculator core with sign-magnitude output for a display driver.
- Accepts one key event per `newkey` pulse: a digit, or one of seven command keys (add, subtract, multiply, equals, backspace, clear all, clear entry).
- Outputs the current entry or result as a 16-bit magnitude, plus a sign flag and an overflow flag.
- Sits between a debounced keypad scanner and the 7-segment display logic.

---
 rtl/hex_calculator.sv | 257 +++++++++++++++++++++++++
 tb/tb_hex_calculator.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_calculator.sv
// hex_calculator: four-digit hexadecimal keypad calculator core.
// Takes one key event per newkey strobe and presents a sign-magnitude
// result (value/sign) plus an overflow flag to the display driver.
module hex_calculator (
    input  logic        clock,
    input  logic        reset,
    input  logic        newkey,
    input  logic [4:0]  keycode,
    output logic        ovw,
    output logic        sign,
    output logic [15:0] value
);

    typedef enum logic [1:0] {
        ST_ENTRY1 = 2'd0,
        ST_OPWAIT = 2'd1,
        ST_ENTRY2 = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_MUL  = 2'd3
    } op_t;

    localparam logic [3:0] KEY_ADD  = 4'hA;
    localparam logic [3:0] KEY_SUB  = 4'h3;
    localparam logic [3:0] KEY_MUL  = 4'h2;
    localparam logic [3:0] KEY_EQ   = 4'h4;
    localparam logic [3:0] KEY_BACK = 4'h1;
    localparam logic [3:0] KEY_CLR  = 4'h9;
    localparam logic [3:0] KEY_CE   = 4'hC;

    // Map a command code onto the pending-operation encoding.
    function automatic op_t decode_op(input logic [3:0] code);
        op_t op_v;
        case (code)
            KEY_ADD: op_v = OP_ADD;
            KEY_SUB: op_v = OP_SUB;
            KEY_MUL: op_v = OP_MUL;
            default: op_v = OP_NONE;
        endcase
        return op_v;
    endfunction

    // Evaluate a op b on sign-magnitude operands; returns {ovw, sign, magnitude}.
    // Operands become 18-bit two's complement, widened to 36 bits so the
    // signed product never wraps.
    function automatic logic [17:0] evaluate(
        input op_t         op,
        input logic        a_neg,
        input logic [15:0] a_mag,
        input logic        b_neg,
        input logic [15:0] b_mag
    );
        logic [17:0]        a18;
        logic [17:0]        b18;
        logic signed [35:0] a_w;
        logic signed [35:0] b_w;
        logic signed [35:0] res;
        logic [35:0]        abs_v;
        a18 = a_neg ? (18'd0 - {2'b00, a_mag}) : {2'b00, a_mag};
        b18 = b_neg ? (18'd0 - {2'b00, b_mag}) : {2'b00, b_mag};
        a_w = {{18{a18[17]}}, a18};
        b_w = {{18{b18[17]}}, b18};
        case (op)
            OP_ADD:  res = a_w + b_w;
            OP_SUB:  res = a_w - b_w;
            OP_MUL:  res = a_w * b_w;
            default: res = 36'sd0;
        endcase
        abs_v = res[35] ? (36'd0 - $unsigned(res)) : $unsigned(res);
        return {(|abs_v[35:16]), res[35], abs_v[15:0]};
    endfunction

    state_t      state_r, state_s;
    op_t         op_r, op_s;
    logic        acc_sign_r, acc_sign_s;
    logic [15:0] acc_mag_r, acc_mag_s;
    logic [15:0] entry_r, entry_s;
    logic        fresh_r, fresh_s;
    logic [15:0] value_r, value_s;
    logic        sign_r, sign_s;
    logic        ovw_r, ovw_s;

    logic        b_neg_s;
    logic [15:0] b_mag_s;
    logic [17:0] result_s;
    logic [15:0] shifted_s;
    logic [15:0] digit_entry_s;

    assign value = value_r;
    assign sign  = sign_r;
    assign ovw   = ovw_r;

    // Second operand: OPWAIT reuses the displayed operand, otherwise the entry.
    always_comb begin
        if (state_r == ST_OPWAIT) begin
            b_neg_s = sign_r;
            b_mag_s = value_r;
        end else begin
            b_neg_s = 1'b0;
            b_mag_s = entry_r;
        end
        result_s      = evaluate(op_r, acc_sign_r, acc_mag_r, b_neg_s, b_mag_s);
        shifted_s     = {4'h0, value_r[15:4]};
        digit_entry_s = {entry_r[11:0], keycode[3:0]};
    end

    // Next-state and datapath decode for one accepted key event.
    always_comb begin
        state_s    = state_r;
        op_s       = op_r;
        acc_sign_s = acc_sign_r;
        acc_mag_s  = acc_mag_r;
        entry_s    = entry_r;
        fresh_s    = fresh_r;
        value_s    = value_r;
        sign_s     = sign_r;
        ovw_s      = ovw_r;
        if (newkey) begin
            if (keycode[4]) begin
                if (fresh_r || (state_r == ST_OPWAIT)) begin
                    // Start a new number
                    entry_s = {12'h000, keycode[3:0]};
                    value_s = {12'h000, keycode[3:0]};
                    sign_s  = 1'b0;
                    ovw_s   = 1'b0;
                    fresh_s = 1'b0;
                    if (state_r == ST_OPWAIT) begin
                        state_s = ST_ENTRY2;
                    end else begin
                        state_s = state_r;
                    end
                end else if (entry_r[15:12] == 4'h0) begin
                    entry_s = digit_entry_s;
                    value_s = digit_entry_s;
                    sign_s  = 1'b0;
                    ovw_s   = 1'b0;
                end else begin
                    // Four digits already entered: drop the key
                    entry_s = entry_r;
                end
            end else begin
                case (keycode[3:0])
                    KEY_ADD, KEY_SUB, KEY_MUL: begin
                        case (state_r)
                            ST_ENTRY1: begin
                                acc_sign_s = sign_r;
                                acc_mag_s  = value_r;
                                op_s       = decode_op(keycode[3:0]);
                                state_s    = ST_OPWAIT;
                            end
                            ST_OPWAIT: begin
                                op_s = decode_op(keycode[3:0]);
                            end
                            ST_ENTRY2: begin
                                // Chained operator: show the running result
                                ovw_s      = result_s[17];
                                sign_s     = result_s[16];
                                value_s    = result_s[15:0];
                                acc_sign_s = result_s[16];
                                acc_mag_s  = result_s[15:0];
                                op_s       = decode_op(keycode[3:0]);
                                fresh_s    = 1'b1;
                                state_s    = ST_OPWAIT;
                            end
                            default: begin
                                state_s = ST_ENTRY1;
                            end
                        endcase
                    end
                    KEY_EQ: begin
                        if ((state_r == ST_ENTRY2) || (state_r == ST_OPWAIT)) begin
                            ovw_s   = result_s[17];
                            sign_s  = result_s[16];
                            value_s = result_s[15:0];
                            op_s    = OP_NONE;
                            fresh_s = 1'b1;
                            state_s = ST_ENTRY1;
                        end else begin
                            state_s = state_r;
                        end
                    end
                    KEY_BACK: begin
                        entry_s = shifted_s;
                        value_s = shifted_s;
                        sign_s  = 1'b0;
                        ovw_s   = 1'b0;
                        fresh_s = 1'b0;
                        if (state_r == ST_OPWAIT) begin
                            state_s = ST_ENTRY2;
                        end else begin
                            state_s = state_r;
                        end
                    end
                    KEY_CLR: begin
                        state_s    = ST_ENTRY1;
                        op_s       = OP_NONE;
                        acc_sign_s = 1'b0;
                        acc_mag_s  = 16'h0000;
                        entry_s    = 16'h0000;
                        fresh_s    = 1'b0;
                        value_s    = 16'h0000;
                        sign_s     = 1'b0;
                        ovw_s      = 1'b0;
                    end
                    KEY_CE: begin
                        entry_s = 16'h0000;
                        value_s = 16'h0000;
                        sign_s  = 1'b0;
                        ovw_s   = 1'b0;
                        fresh_s = 1'b0;
                        if (state_r == ST_ENTRY1) begin
                            acc_sign_s = 1'b0;
                            acc_mag_s  = 16'h0000;
                        end else begin
                            state_s = ST_ENTRY2;
                        end
                    end
                    default: begin
                        state_s = state_r;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // State and display registers; reset wins over any strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_ENTRY1;
            op_r       <= OP_NONE;
            acc_sign_r <= 1'b0;
            acc_mag_r  <= 16'h0000;
            entry_r    <= 16'h0000;
            fresh_r    <= 1'b0;
            value_r    <= 16'h0000;
            sign_r     <= 1'b0;
            ovw_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            op_r       <= op_s;
            acc_sign_r <= acc_sign_s;
            acc_mag_r  <= acc_mag_s;
            entry_r    <= entry_s;
            fresh_r    <= fresh_s;
            value_r    <= value_s;
            sign_r     <= sign_s;
            ovw_r      <= ovw_s;
        end
    end

endmodule

// File: tb/tb_hex_calculator.sv
// Self-checking bench for hex_calculator: directed key sequences with
// known answers plus random key streams checked against a calculator model.
module tb_hex_calculator;

    logic        clock;
    logic        reset;
    logic        newkey;
    logic [4:0]  keycode;
    logic        ovw;
    logic        sign;
    logic [15:0] value;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [4:0] K_ADD  = 5'h0A;
    localparam logic [4:0] K_SUB  = 5'h03;
    localparam logic [4:0] K_MUL  = 5'h02;
    localparam logic [4:0] K_EQ   = 5'h04;
    localparam logic [4:0] K_BACK = 5'h01;
    localparam logic [4:0] K_CLR  = 5'h09;
    localparam logic [4:0] K_CE   = 5'h0C;

    localparam int S_E1 = 0;
    localparam int S_OW = 1;
    localparam int S_E2 = 2;

    // Calculator model: values held as plain signed integers
    int     m_state;
    int     m_op;
    longint m_acc;
    int     m_entry;
    bit     m_fresh;
    int     m_val;
    bit     m_neg;
    bit     m_ovw;

    hex_calculator dut (
        .clock   (clock),
        .reset   (reset),
        .newkey  (newkey),
        .keycode (keycode),
        .ovw     (ovw),
        .sign    (sign),
        .value   (value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic longint calc(input int op, input longint a, input longint b);
        if (op == 10) return a + b;
        else if (op == 3) return a - b;
        else if (op == 2) return a * b;
        else return 64'sd0;
    endfunction

    task automatic model_reset();
        m_state = S_E1; m_op = 0; m_acc = 0; m_entry = 0;
        m_fresh = 1'b0; m_val = 0; m_neg = 1'b0; m_ovw = 1'b0;
    endtask

    task automatic show_result(input longint r);
        longint a;
        a = (r < 0) ? -r : r;
        m_neg = (r < 0);
        m_ovw = (a > 64'sd65535);
        m_val = int'(a % 64'sd65536);
    endtask

    function automatic longint shown();
        return m_neg ? -longint'(m_val) : longint'(m_val);
    endfunction

    task automatic model_key(input logic [4:0] k);
        int c;
        longint r;
        c = int'(k[3:0]);
        if (k[4]) begin
            if (m_fresh || m_state == S_OW) begin
                m_entry = c;
                m_fresh = 1'b0;
                if (m_state == S_OW) m_state = S_E2;
                m_val = m_entry; m_neg = 1'b0; m_ovw = 1'b0;
            end else if (m_entry < 4096) begin
                m_entry = m_entry * 16 + c;
                m_val = m_entry; m_neg = 1'b0; m_ovw = 1'b0;
            end
        end else if (c == 10 || c == 3 || c == 2) begin
            if (m_state == S_E1) begin
                m_acc = shown(); m_op = c; m_state = S_OW;
            end else if (m_state == S_OW) begin
                m_op = c;
            end else begin
                r = calc(m_op, m_acc, longint'(m_entry));
                show_result(r);
                m_acc = shown();
                m_op = c; m_state = S_OW; m_fresh = 1'b1;
            end
        end else if (c == 4) begin
            if (m_state != S_E1) begin
                if (m_state == S_E2) r = calc(m_op, m_acc, longint'(m_entry));
                else r = calc(m_op, m_acc, shown());
                show_result(r);
                m_state = S_E1; m_op = 0; m_fresh = 1'b1;
            end
        end else if (c == 1) begin
            m_val = m_val / 16; m_entry = m_val;
            m_neg = 1'b0; m_ovw = 1'b0; m_fresh = 1'b0;
            if (m_state == S_OW) m_state = S_E2;
        end else if (c == 9) begin
            model_reset();
        end else if (c == 12) begin
            m_entry = 0; m_val = 0; m_neg = 1'b0; m_ovw = 1'b0; m_fresh = 1'b0;
            if (m_state == S_E1) m_acc = 0;
            else m_state = S_E2;
        end
    endtask

    // One strobed key; keycode is scrambled afterwards to mimic bounce
    task automatic press(input logic [4:0] k);
        @(negedge clock);
        newkey  = 1'b1;
        keycode = k;
        @(negedge clock);
        newkey  = 1'b0;
        keycode = 5'($urandom);
        model_key(k);
    endtask

    task automatic test_reset();
        reset = 1'b1; newkey = 1'b0; keycode = 5'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        vectors++;
        if ({ovw, sign, value} !== {1'b0, 1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_state: ovw=%b sign=%b value=%h, expected 0/0/0000", ovw, sign, value);
        end
    endtask

    task automatic test_bounce();
        press(K_CLR);
        @(negedge clock); keycode = 5'h15;
        @(negedge clock); keycode = 5'h02;
        @(negedge clock); keycode = 5'h1D;
        newkey = 1'b1;
        @(negedge clock); newkey = 1'b0; keycode = 5'h15;
        model_key(5'h1D);
        @(negedge clock);
        vectors++;
        if (value !== 16'h000D) begin
            miscompares++;
            $display("FAIL bounce_digit: value=%h, expected 000D", value);
        end
        press(K_SUB); press(5'h1F); press(K_EQ);
        vectors++;
        if ({ovw, sign, value} !== {1'b0, 1'b1, 16'h0002}) begin
            miscompares++;
            $display("FAIL bounce_result: ovw=%b sign=%b value=%h, expected 0/1/0002", ovw, sign, value);
        end
    endtask

    task automatic test_digits_back();
        press(K_CLR);
        press(5'h15); press(5'h15); press(5'h15);
        vectors++;
        if (value !== 16'h0555) begin
            miscompares++;
            $display("FAIL digit_shift: value=%h, expected 0555", value);
        end
        press(K_BACK); press(K_BACK);
        vectors++;
        if (value !== 16'h0005) begin
            miscompares++;
            $display("FAIL back_twice: value=%h, expected 0005", value);
        end
        press(5'h15); press(K_ADD); press(K_EQ);
        vectors++;
        if ({ovw, sign, value} !== {1'b0, 1'b0, 16'h00AA}) begin
            miscompares++;
            $display("FAIL add_self: ovw=%b sign=%b value=%h, expected 0/0/00AA", ovw, sign, value);
        end
    endtask

    task automatic test_self_ops();
        press(K_CLR);
        press(5'h15); press(K_SUB); press(K_EQ);
        vectors++;
        if ({ovw, sign, value} !== {1'b0, 1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL sub_self: ovw=%b sign=%b value=%h, expected 0/0/0000", ovw, sign, value);
        end
        press(K_SUB); press(5'h11); press(K_EQ);
        vectors++;
        if ({ovw, sign, value} !== {1'b0, 1'b1, 16'h0001}) begin
            miscompares++;
            $display("FAIL zero_minus_one: ovw=%b sign=%b value=%h, expected 0/1/0001", ovw, sign, value);
        end
        press(5'h15); press(K_MUL); press(K_EQ);
        vectors++;
        if ({ovw, sign, value} !== {1'b0, 1'b0, 16'h0019}) begin
            miscompares++;
            $display("FAIL mul_self: ovw=%b sign=%b value=%h, expected 0/0/0019", ovw, sign, value);
        end
    endtask

    task automatic test_chain_back_clr();
        press(K_CLR);
        press(5'h15); press(5'h15); press(K_ADD); press(5'h15); press(K_EQ);
        vectors++;
        if (value !== 16'h005A) begin
            miscompares++;
            $display("FAIL add_55_5: value=%h, expected 005A", value);
        end
        press(K_BACK);
        vectors++;
        if (value !== 16'h0005) begin
            miscompares++;
            $display("FAIL back_result: value=%h, expected 0005", value);
        end
        press(K_CLR);
        vectors++;
        if ({ovw, sign, value} !== {1'b0, 1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL clr_key: ovw=%b sign=%b value=%h, expected 0/0/0000", ovw, sign, value);
        end
        press(5'h12); press(K_ADD); press(5'h13); press(K_MUL);
        vectors++;
        if (value !== 16'h0005) begin
            miscompares++;
            $display("FAIL chain_partial: value=%h, expected 0005", value);
        end
        press(5'h14); press(K_EQ);
        vectors++;
        if (value !== 16'h0014) begin
            miscompares++;
            $display("FAIL chain_result: value=%h, expected 0014", value);
        end
        press(K_EQ);
        vectors++;
        if (value !== 16'h0014) begin
            miscompares++;
            $display("FAIL eq_no_op: value=%h, expected 0014", value);
        end
    endtask

    task automatic test_ce();
        press(K_CLR);
        press(5'h15); press(K_ADD); press(5'h14); press(K_CE);
        vectors++;
        if (value !== 16'h0000) begin
            miscompares++;
            $display("FAIL ce_display: value=%h, expected 0000", value);
        end
        press(5'h13); press(K_EQ);
        vectors++;
        if (value !== 16'h0008) begin
            miscompares++;
            $display("FAIL ce_keeps_op: value=%h, expected 0008", value);
        end
        press(5'h1C); press(5'h0F); press(5'h00);
        vectors++;
        if (value !== 16'h000C) begin
            miscompares++;
            $display("FAIL unused_cmd: value=%h, expected 000C", value);
        end
    endtask

    task automatic test_overflow_limits();
        press(K_CLR);
        for (int i = 0; i < 4; i++) press(5'h1F);
        press(K_MUL); press(5'h11); press(5'h10); press(K_EQ);
        vectors++;
        if ({ovw, sign, value} !== {1'b1, 1'b0, 16'hFFF0}) begin
            miscompares++;
            $display("FAIL mul_overflow: ovw=%b sign=%b value=%h, expected 1/0/FFF0", ovw, sign, value);
        end
        press(K_CLR);
        for (int i = 1; i <= 5; i++) press(5'h10 | 5'(i));
        vectors++;
        if (value !== 16'h1234) begin
            miscompares++;
            $display("FAIL fifth_digit: value=%h, expected 1234", value);
        end
    endtask

    task automatic test_reset_override();
        press(K_CLR); press(5'h17); press(K_ADD); press(5'h18);
        @(negedge clock);
        newkey = 1'b1; keycode = K_EQ; reset = 1'b1;
        @(negedge clock);
        newkey = 1'b0; keycode = 5'h1F;
        vectors++;
        if ({ovw, sign, value} !== {1'b0, 1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_override: ovw=%b sign=%b value=%h, expected 0/0/0000", ovw, sign, value);
        end
        reset = 1'b0;
        model_reset();
        press(5'h16); press(K_EQ);
        vectors++;
        if (value !== 16'h0006) begin
            miscompares++;
            $display("FAIL after_reset: value=%h, expected 0006", value);
        end
        press(5'h13);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({ovw, sign, value} !== {1'b0, 1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL async_reset: ovw=%b sign=%b value=%h, expected 0/0/0000", ovw, sign, value);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        int r;
        logic [4:0] k;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) k = {1'b1, 4'($urandom)};
            else if (r < 57) k = K_CLR;
            else if (r < 68) begin
                case ($urandom_range(0, 2))
                    0: k = K_ADD;
                    1: k = K_SUB;
                    default: k = K_MUL;
                endcase
            end
            else if (r < 80) k = K_EQ;
            else if (r < 86) k = K_BACK;
            else if (r < 90) k = K_CE;
            else k = {1'b0, 4'($urandom)};
            repeat ($urandom_range(0, 2)) @(negedge clock);
            press(k);
            vectors++;
            if ({ovw, sign, value} !== {m_ovw, m_neg, 16'(m_val)}) begin
                miscompares++;
                $display("FAIL random_key%0d code=%h: ovw=%b sign=%b value=%h, expected %b/%b/%h",
                         i, k, ovw, sign, value, m_ovw, m_neg, 16'(m_val));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        newkey = 1'b0;
        keycode = 5'h00;
        test_reset();
        test_bounce();
        test_digits_back();
        test_self_ops();
        test_chain_back_clr();
        test_ce();
        test_overflow_limits();
        test_reset_override();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
